// File: rtl/cbfp_seq_ctrl_if.sv
// Handshake bundle between the upstream butterfly, the CBFP sequencing controller and its datapath.
// CBFP_CTRL_FLUSH_EN adds the synchronous flush input.
interface cbfp_seq_ctrl_if #(
  parameter int BEAT_W    = 2,
  parameter int BLK_CNT_W = 8
);
  logic                 valid_in;
`ifdef CBFP_CTRL_FLUSH_EN
  logic                 flush;
`endif
  logic                 wr_en;
  logic                 wr_bank;
  logic [BEAT_W-1:0]    wr_beat;
  logic                 cal_clr;
  logic                 cal_en;
  logic                 cal_done;
  logic                 rd_en;
  logic                 rd_bank;
  logic [BEAT_W-1:0]    rd_beat;
  logic [BEAT_W-1:0]    cnt_sel;
  logic                 valid_out;
  logic                 busy;
  logic                 ovf_err;
  logic [BLK_CNT_W-1:0] blk_cnt;

  modport master (
`ifdef CBFP_CTRL_FLUSH_EN
    output flush,
`endif
    output valid_in,
    input  wr_en, wr_bank, wr_beat, cal_clr, cal_en, cal_done,
    input  rd_en, rd_bank, rd_beat, cnt_sel, valid_out, busy, ovf_err, blk_cnt
  );

  modport slave (
`ifdef CBFP_CTRL_FLUSH_EN
    input  flush,
`endif
    input  valid_in,
    output wr_en, wr_bank, wr_beat, cal_clr, cal_en, cal_done,
    output rd_en, rd_bank, rd_beat, cnt_sel, valid_out, busy, ovf_err, blk_cnt
  );
endinterface

// File: rtl/cbfp_seq_ctrl.sv
// CBFP sequencing controller: fills a two-bank block buffer, frames the zero count, drains through the shifter.
// Optional synchronous flush input is enabled by defining CBFP_CTRL_FLUSH_EN.
module cbfp_seq_ctrl #(
  parameter int BEATS     = 4,
  parameter int BEAT_W    = 2,
  parameter int CAL_LAT   = 2,
  parameter int BLK_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rstn,
  cbfp_seq_ctrl_if.slave bus
);

  localparam int TMR_W = (CAL_LAT > 1) ? $clog2(CAL_LAT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [TMR_W-1:0]  TMR_INIT  = TMR_W'(CAL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_wr_bank;
  logic [BEAT_W-1:0]    r_wr_beat;
  logic                 r_drop;
  logic [1:0]           r_pend;
  logic                 r_cal_done;
  logic                 r_ovf_err;
  logic                 r_rd_en;
  logic                 r_rd_bank;
  logic [BEAT_W-1:0]    r_rd_beat;
  logic [BLK_CNT_W-1:0] r_blk_cnt;

  logic       w_flush;
  logic       w_valid;
  logic       w_first;
  logic       w_last;
  logic       w_ovf;
  logic       w_drop;
  logic       w_set;
  logic       w_rd_last;
  logic [1:0] w_set_mask;
  logic [1:0] w_clr_mask;

`ifdef CBFP_CTRL_FLUSH_EN
  assign w_flush = bus.flush;
`else
  assign w_flush = 1'b0;
`endif

  // The overflow decision on beat 0 must already gate that beat, so drop is the register OR the live hit.
  assign w_valid    = bus.valid_in & ~w_flush;
  assign w_first    = (r_wr_beat == '0);
  assign w_last     = w_valid & (r_wr_beat == LAST_BEAT);
  assign w_ovf      = w_valid & w_first & r_pend[r_wr_bank];
  assign w_drop     = r_drop | w_ovf;
  assign w_set      = w_last & ~w_drop;
  assign w_rd_last  = (r_state == S_DRAIN) && (r_rd_beat == LAST_BEAT);
  assign w_set_mask = {w_set & r_wr_bank, w_set & ~r_wr_bank};
  assign w_clr_mask = {w_rd_last & r_rd_bank, w_rd_last & ~r_rd_bank};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_bank  <= 1'b0;
      r_wr_beat  <= '0;
      r_drop     <= 1'b0;
      r_cal_done <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else if (w_flush) begin
      r_wr_bank  <= 1'b0;
      r_wr_beat  <= '0;
      r_drop     <= 1'b0;
      r_cal_done <= 1'b0;
    end else begin
      r_cal_done <= w_set;
      if (w_ovf) r_ovf_err <= 1'b1;
      if (w_valid) begin
        r_wr_beat <= r_wr_beat + BEAT_W'(1);
        if (w_last) begin
          r_drop <= 1'b0;
          if (!w_drop) r_wr_bank <= ~r_wr_bank;
        end else if (w_ovf) begin
          r_drop <= 1'b1;
        end
      end
    end
  end

  // Set and clear always target different banks, because a pending bank refuses new blocks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pend <= 2'b00;
    else if (w_flush) r_pend <= 2'b00;
    else r_pend <= (r_pend | w_set_mask) & ~w_clr_mask;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_rd_en   <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rd_beat <= '0;
      r_blk_cnt <= '0;
    end else if (w_flush) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_rd_en   <= 1'b0;
      r_rd_bank <= 1'b0;
      r_rd_beat <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend[r_rd_bank]) begin
            r_state <= S_WAIT;
            r_timer <= TMR_INIT;
          end
        end
        S_WAIT: begin
          if (r_timer == '0) begin
            r_state   <= S_DRAIN;
            r_rd_beat <= '0;
            r_rd_en   <= 1'b1;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        S_DRAIN: begin
          r_rd_beat <= r_rd_beat + BEAT_W'(1);
          if (w_rd_last) begin
            r_state   <= S_IDLE;
            r_rd_en   <= 1'b0;
            r_rd_bank <= ~r_rd_bank;
            r_blk_cnt <= r_blk_cnt + BLK_CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en     = w_valid & ~w_drop;
  assign bus.wr_bank   = r_wr_bank;
  assign bus.wr_beat   = r_wr_beat;
  assign bus.cal_en    = w_valid & ~w_drop;
  assign bus.cal_clr   = w_valid & ~w_drop & w_first;
  assign bus.cal_done  = r_cal_done;
  assign bus.rd_en     = r_rd_en;
  assign bus.rd_bank   = r_rd_bank;
  assign bus.rd_beat   = r_rd_beat;
  assign bus.cnt_sel   = r_rd_beat;
  assign bus.valid_out = r_rd_en;
  assign bus.busy      = (|r_pend) | (r_state != S_IDLE);
  assign bus.ovf_err   = r_ovf_err;
  assign bus.blk_cnt   = r_blk_cnt;

endmodule

// File: doc/cbfp_seq_ctrl.md
Name: cbfp_seq_ctrl

Overview:
Sequencing controller for the CBFP stage. It tracks 16-lane input beats into 64-sample blocks and steers a two-bank block buffer with write and read strobes. It also frames the per-block zero-count calculation, then schedules the drain through the output shifter, with the matching zero-count select per beat. It sits between the upstream FFT butterfly valid and the CBFP buffer, zero-count and shift datapath.

Parameters:
BEATS, 4, beats (of array_size lanes) per CBFP block; must be a power of 2
BEAT_W, 2, log2(BEATS)
CAL_LAT, 2, cycles from block-complete to zero count valid; must be >= 1
BLK_CNT_W, 8, width of drained-block counter

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
valid_in  in  1  one input beat present this cycle
wr_en  out  1  write current beat to buffer (combinational: valid_in & ~drop)
wr_bank  out  1  buffer bank being filled
wr_beat  out  BEAT_W  beat index within block being written
cal_clr  out  1  clear zero-count accumulator (combinational: wr_en & wr_beat==0)
cal_en  out  1  accumulate zero count this beat (= wr_en)
cal_done  out  1  registered 1-cycle pulse after last accepted beat of a block
rd_en  out  1  read buffer beat (registered)
rd_bank  out  1  bank being drained
rd_beat  out  BEAT_W  beat index being drained
cnt_sel  out  BEAT_W  zero-count group select for shifter (= rd_beat)
valid_out  out  1  shifter output valid (= rd_en)
busy  out  1  any bank pending or read FSM not IDLE
ovf_err  out  1  sticky: a block was dropped
blk_cnt  out  BLK_CNT_W  drained blocks, wraps modulo 2^BLK_CNT_W

Behaviour:
- Reset (async, rstn=0):
  - wr_bank=0, wr_beat=0, rd_bank=0, rd_beat=0
  - pend[1:0]=0, drop=0, state=IDLE
  - cal_done=0, rd_en=0, ovf_err=0, blk_cnt=0
  - Reset mid-block discards the partial block and all pending blocks.
- Write side:
  - Each valid_in cycle increments wr_beat, wrapping at BEATS-1 to 0.
  - At wr_beat==0 with valid_in: if pend[wr_bank]=1, then drop=1 for the whole block and ovf_err is set.
  - While drop=1, wr_en, cal_en and cal_clr stay 0, but wr_beat still counts.
  - drop clears after the block's last beat.
- Last beat (valid_in & wr_beat==BEATS-1):
  - If not dropped: pend[wr_bank]<=1, wr_bank toggles, and cal_done pulses next cycle.
  - If dropped: nothing changes except drop<=0.
- Gaps in valid_in are allowed anywhere; counters hold during gaps.
- Read FSM:
  - IDLE: if pend[rd_bank], go to WAIT with timer=CAL_LAT-1.
  - WAIT: decrement timer; at 0, go to DRAIN with rd_beat=0.
  - DRAIN: rd_en=1 and rd_beat increments each cycle.
  - At rd_beat==BEATS-1: clear pend[rd_bank], toggle rd_bank, increment blk_cnt, go to IDLE.
- Timing:
  - First rd_en is asserted at (last write cycle + 2 + CAL_LAT).
  - IDLE always costs 1 bubble cycle between drains.
- Concurrency:
  - Set of pend[wr_bank] and clear of pend[rd_bank] in the same cycle are on different banks and both take effect.
  - The same bank can never be set and cleared in one cycle: pend gates acceptance.
- Sustained input without drops requires >= CAL_LAT+1 idle cycles between blocks.
- Write side and read side operate concurrently.

Optional Feature:
- Macro: CBFP_CTRL_FLUSH_EN.
- Defined: adds input port flush (1 bit, synchronous). flush=1 clears wr_beat, drop, pend, rd_beat, rd_en and cal_done, and forces state=IDLE and both banks to 0. ovf_err and blk_cnt are retained. flush overrides valid_in in the same cycle, so that beat is discarded.
- Undefined: no port, no logic.

Test Plan:
- Single block, valid_in at cycles 0-3 -> wr_beat 0,1,2,3; cal_clr at cycle 0 only; cal_done at cycle 4; rd_en cycles 7-10 with rd_beat/cnt_sel 0-3 and rd_bank=0; blk_cnt=1 at cycle 11; busy=0 at cycle 11.
- Back-to-back blocks, valid_in at cycles 0-7 -> block 2 goes to bank 1; rd_bank=1 drain at cycles 14-17; blk_cnt=2; ovf_err=0.
- Overflow, continuous valid_in at cycles 0-11 -> block 3 (beat 0 at cycle 8, pend[0]=1) is dropped: wr_en=0 at cycles 8-11 and ovf_err=1 from cycle 9; only 2 drains occur.
- Gapped input, valid_in at cycles 0,2,5,9 -> cal_done at cycle 10; rd_en at cycles 13-16.
- Reset mid-drain, rstn low at cycle 8 of the single-block case -> all outputs return to reset values immediately; no further rd_en until new input.
- Flush (CBFP_CTRL_FLUSH_EN defined), flush at cycle 2 of a block -> wr_beat=0 next cycle; no cal_done; no rd_en; blk_cnt unchanged.
